// File: rtl/exe_stage.sv
// Execute stage: ALU, branch resolution, EXE/MEM pipeline register and an
// iterative shift-add multiplier that stalls upstream while it runs.
//
// state | meaning
// IDLE  | single-cycle ops flow through; a valid MUL latches operands and stalls
// BUSY  | one shift-add step per cycle, upstream frozen, EXE/MEM gets bubbles
// DONE  | product ready; EXE/MEM loads it with the held passthrough fields
module exe_stage #(
    parameter int len = 32
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [len-1:0] pc_in,
    input  logic           wb_en_in,
    input  logic           mem_read_in,
    input  logic           mem_write_in,
    input  logic           flush_in,
    input  logic [1:0]     branch_type,
    input  logic [3:0]     exe_cmd,
    input  logic [31:0]    reg2_in,
    input  logic [31:0]    alu_inp1,
    input  logic [31:0]    alu_inp2,
    input  logic [4:0]     dest_in,
    output logic           branch_taken,
    output logic [len-1:0] branch_addr,
    output logic           stall,
    output logic [len-1:0] pc_out,
    output logic           wb_en_out,
    output logic           mem_read_out,
    output logic           mem_write_out,
    output logic [31:0]    alu_result_out,
    output logic [31:0]    reg2_out,
    output logic [4:0]     dest_out
);

    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0100;
    localparam logic [3:0] CMD_OR  = 4'b0101;
    localparam logic [3:0] CMD_NOR = 4'b0110;
    localparam logic [3:0] CMD_XOR = 4'b0111;
    localparam logic [3:0] CMD_SLL = 4'b1000;
    localparam logic [3:0] CMD_SRA = 4'b1001;
    localparam logic [3:0] CMD_SRL = 4'b1010;
    localparam logic [3:0] CMD_MUL = 4'b1100;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {SEL_BUBBLE, SEL_ALU, SEL_ACC} out_sel_t;

    state_t     state, state_next;
    out_sel_t   out_sel;
    logic [31:0] mcand, mplier, acc;
    logic [4:0]  count;
    logic [31:0] alu_result;
    logic        valid, start_mul, branch_cond;

    assign valid     = ~flush_in;
    assign start_mul = valid & (exe_cmd == CMD_MUL);

    always_comb begin
        alu_result = alu_inp1;
        case (exe_cmd)
            CMD_ADD: alu_result = alu_inp1 + alu_inp2;
            CMD_SUB: alu_result = alu_inp1 - alu_inp2;
            CMD_AND: alu_result = alu_inp1 & alu_inp2;
            CMD_OR:  alu_result = alu_inp1 | alu_inp2;
            CMD_NOR: alu_result = ~(alu_inp1 | alu_inp2);
            CMD_XOR: alu_result = alu_inp1 ^ alu_inp2;
            CMD_SLL: alu_result = alu_inp1 << alu_inp2[4:0];
            CMD_SRA: alu_result = $unsigned($signed(alu_inp1) >>> alu_inp2[4:0]);
            CMD_SRL: alu_result = alu_inp1 >> alu_inp2[4:0];
            default: alu_result = alu_inp1;
        endcase
    end

    always_comb begin
        branch_cond = 1'b0;
        case (branch_type)
            2'b01:   branch_cond = (alu_inp1 == 32'd0);
            2'b10:   branch_cond = (alu_inp1 != reg2_in);
            2'b11:   branch_cond = 1'b1;
            default: branch_cond = 1'b0;
        endcase
    end

    // Redirects are suppressed while a multiply owns the stage.
    assign branch_taken = (state == IDLE) & valid & branch_cond;
    assign branch_addr  = pc_in + len'({alu_inp2[29:0], 2'b00});

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        out_sel    = SEL_BUBBLE;
        case (state)
            IDLE: begin
                if (start_mul) begin
                    stall      = 1'b1;
                    state_next = BUSY;
                end else if (valid) begin
                    out_sel = SEL_ALU;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (count == 5'd31) state_next = DONE;
            end
            DONE: begin
                out_sel    = SEL_ACC;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start_mul) begin
                mcand  <= alu_inp1;
                mplier <= alu_inp2;
                acc    <= '0;
                count  <= '0;
            end else if (state == BUSY) begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + 5'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || out_sel == SEL_BUBBLE) begin
            pc_out         <= '0;
            wb_en_out      <= 1'b0;
            mem_read_out   <= 1'b0;
            mem_write_out  <= 1'b0;
            alu_result_out <= '0;
            reg2_out       <= '0;
            dest_out       <= '0;
        end else begin
            pc_out         <= pc_in;
            wb_en_out      <= wb_en_in;
            mem_read_out   <= mem_read_in;
            mem_write_out  <= mem_write_in;
            alu_result_out <= (out_sel == SEL_ACC) ? acc : alu_result;
            reg2_out       <= reg2_in;
            dest_out       <= dest_in;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Directed plus randomized bench for exe_stage, checked against an
// arithmetic reference model of the ALU, branch unit and multiply timing.
module tb_exe_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        wb_en_in, mem_read_in, mem_write_in, flush_in;
    logic [1:0]  branch_type;
    logic [3:0]  exe_cmd;
    logic [31:0] reg2_in, alu_inp1, alu_inp2;
    logic [4:0]  dest_in;
    logic        branch_taken, stall;
    logic [31:0] branch_addr, pc_out;
    logic        wb_en_out, mem_read_out, mem_write_out;
    logic [31:0] alu_result_out, reg2_out;
    logic [4:0]  dest_out;

    int vectors = 0;
    int miscompares = 0;

    exe_stage #(.len(32)) dut (
        .clock(clock), .reset(reset), .pc_in(pc_in),
        .wb_en_in(wb_en_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .flush_in(flush_in), .branch_type(branch_type), .exe_cmd(exe_cmd),
        .reg2_in(reg2_in), .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .dest_in(dest_in),
        .branch_taken(branch_taken), .branch_addr(branch_addr), .stall(stall),
        .pc_out(pc_out), .wb_en_out(wb_en_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .alu_result_out(alu_result_out),
        .reg2_out(reg2_out), .dest_out(dest_out)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] p, w;
        p = 64'd1;
        repeat (int'(b[4:0])) p = p * 64'd2;
        case (cmd)
            4'b0000: return a + b;
            4'b0010: return a - b;
            4'b0100: return a & b;
            4'b0101: return a | b;
            4'b0110: return ~(a | b);
            4'b0111: return a ^ b;
            4'b1000: begin w = {32'd0, a} * p; return w[31:0]; end
            4'b1010: return a / p[31:0];
            4'b1001: return a[31] ? ~((~a) / p[31:0]) : a / p[31:0];
            4'b1100: begin w = {32'd0, a} * {32'd0, b}; return w[31:0]; end
            default: return a;
        endcase
    endfunction

    function automatic logic ref_taken(input logic fl, input logic [1:0] bt,
                                       input logic [31:0] a, input logic [31:0] r2);
        if (fl) return 1'b0;
        return (bt == 2'd1 && a == 0) || (bt == 2'd2 && a != r2) || bt == 2'd3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic wb, input logic mr,
                             input logic mw, input logic fl, input logic [1:0] bt,
                             input logic [3:0] cmd, input logic [31:0] r2,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
        pc_in = pc; wb_en_in = wb; mem_read_in = mr; mem_write_in = mw; flush_in = fl;
        branch_type = bt; exe_cmd = cmd; reg2_in = r2; alu_inp1 = a; alu_inp2 = b; dest_in = d;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc, input logic wb,
                           input logic mr, input logic mw, input logic [31:0] res,
                           input logic [31:0] r2, input logic [4:0] d);
        chk({tag, ".pc"}, pc_out, pc);
        chk({tag, ".ctrl"}, {29'd0, wb_en_out, mem_read_out, mem_write_out}, {29'd0, wb, mr, mw});
        chk({tag, ".res"}, alu_result_out, res);
        chk({tag, ".reg2"}, reg2_out, r2);
        chk({tag, ".dest"}, {27'd0, dest_out}, {27'd0, d});
    endtask

    task automatic chk_bubble(input string tag);
        chk_out(tag, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    endtask

    // Non-MUL instruction already on the inputs: combinational checks, then one edge.
    task automatic run_single(input string tag);
        logic [31:0] pc, r2, a, b;
        logic        wb, mr, mw, fl;
        logic [4:0]  d;
        logic [3:0]  cmd;
        pc = pc_in; r2 = reg2_in; a = alu_inp1; b = alu_inp2; d = dest_in; cmd = exe_cmd;
        wb = wb_en_in; mr = mem_read_in; mw = mem_write_in; fl = flush_in;
        #1;
        chk({tag, ".stall"}, stall, 0);
        chk({tag, ".taken"}, branch_taken, ref_taken(fl, branch_type, a, r2));
        chk({tag, ".baddr"}, branch_addr, pc + b * 32'd4);
        tick();
        if (fl) chk_bubble(tag);
        else chk_out(tag, pc, wb, mr, mw, ref_alu(cmd, a, b), r2, d);
    endtask

    // noisy: during the multiply raise flush and JMP, which must both be ignored.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic noisy);
        logic [31:0] pc, r2;
        logic [4:0]  d;
        pc = $urandom; r2 = $urandom; d = 5'($urandom);
        set_instr(pc, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1100, r2, a, b, d);
        for (int i = 0; i < 33; i++) begin
            #1;
            chk({tag, ".stall"}, stall, 1);
            chk({tag, ".taken"}, branch_taken, 0);
            tick();
            chk_bubble({tag, ".busy"});
            if (noisy && i == 0) begin
                flush_in = 1'b1;
                branch_type = 2'd3;
            end
        end
        #1;
        chk({tag, ".done_stall"}, stall, 0);
        chk({tag, ".done_taken"}, branch_taken, 0);
        tick();
        chk_out(tag, pc, 1'b1, 1'b0, 1'b0, ref_alu(4'b1100, a, b), r2, d);
    endtask

    initial begin
        logic [3:0]  cmds [12];
        logic [1:0]  bt;
        cmds = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                 4'b1000, 4'b1001, 4'b1010, 4'b0011, 4'b1111, 4'b0001};

        reset = 1'b1;
        set_instr(0, 0, 0, 0, 0, 2'd0, 4'd0, 0, 0, 0, 5'd0);
        tick();
        tick();
        chk_bubble("reset");
        chk("reset.stall", stall, 0);
        chk("reset.taken", branch_taken, 0);
        reset = 1'b0;

        set_instr(32'h40, 1, 0, 0, 0, 2'd0, 4'b0000, 32'h1234, 32'h7FFFFFFF, 32'd1, 5'd5);
        run_single("add");
        chk("add_const", alu_result_out, 32'h80000000);
        set_instr(32'h44, 1, 0, 0, 0, 2'd0, 4'b1001, 0, 32'hF0000000, 32'd4, 5'd6);
        run_single("sra");
        chk("sra_const", alu_result_out, 32'hFF000000);
        set_instr(32'h48, 1, 0, 0, 0, 2'd0, 4'b1010, 0, 32'hF0000000, 32'd4, 5'd7);
        run_single("srl");
        chk("srl_const", alu_result_out, 32'h0F000000);
        set_instr(32'h4C, 1, 0, 1, 0, 2'd0, 4'b1000, 0, 32'h80000003, 32'h21, 5'd8);
        run_single("sll");
        chk("sll_const", alu_result_out, 32'h00000006);

        set_instr(32'h100, 0, 0, 0, 0, 2'd1, 4'd0, 32'd9, 32'd0, 32'hFFFFFFFE, 5'd0);
        run_single("bez");
        chk("bez_taken", branch_taken, 1);
        chk("bez_addr", branch_addr, 32'hF8);
        set_instr(32'h100, 0, 0, 0, 0, 2'd2, 4'd0, 32'd7, 32'd7, 32'hFFFFFFFE, 5'd0);
        run_single("bne_eq");
        chk("bne_eq_taken", branch_taken, 0);
        set_instr(32'h100, 0, 0, 0, 1, 2'd3, 4'd0, 32'd7, 32'd7, 32'hFFFFFFFE, 5'd0);
        run_single("jmp_flushed");
        chk("jmp_flushed_taken", branch_taken, 0);

        run_mul("mul_a", 32'h00010003, 32'h00000005, 1'b0);
        chk("mul_a_const", alu_result_out, 32'h0005000F);
        run_mul("mul_b", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        chk("mul_b_const", alu_result_out, 32'h00000001);

        set_instr(32'h200, 1, 0, 0, 0, 2'd0, 4'b1100, 0, 32'd123, 32'd456, 5'd9);
        tick();
        repeat (10) tick();
        chk("abort.busy_stall", stall, 1);
        reset = 1'b1;
        set_instr(32'h204, 1, 0, 0, 0, 2'd0, 4'b0000, 32'd1, 32'd10, 32'd20, 5'd3);
        tick();
        reset = 1'b0;
        chk("abort.stall", stall, 0);
        chk("abort.taken", branch_taken, 0);
        chk_bubble("abort");
        run_single("add_after_abort");
        chk("add_after_abort_const", alu_result_out, 32'd30);

        run_mul("b2b_1", $urandom, $urandom, 1'b0);
        run_mul("b2b_2", $urandom, $urandom, 1'b0);
        set_instr(32'h300, 1, 0, 0, 0, 2'd0, 4'b0000, 0, 32'd1, 32'd2, 5'd4);
        run_single("b2b_add");

        for (int i = 0; i < 80; i++) begin
            if (i % 20 == 19) begin
                run_mul("rnd_mul", $urandom, $urandom, 1'($urandom));
            end else begin
                bt = 2'($urandom);
                set_instr($urandom, (bt == 2'd0) ? 1'($urandom) : 1'b0, 1'($urandom),
                          1'($urandom), ($urandom_range(0, 3) == 0), bt,
                          cmds[$urandom_range(0, 11)], ($urandom_range(0, 3) == 0) ? 32'd5 : $urandom,
                          ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, $urandom, 5'($urandom));
                if (bt == 2'd2 && $urandom_range(0, 1) == 0) reg2_in = alu_inp1;
                run_single("rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage pipeline; consumes the ID/EXE pipeline register outputs directly.
- Computes the ALU result, resolves branches, and registers results into the EXE/MEM boundary.
- Contains an iterative 32-cycle multiplier, plus stall control that freezes upstream stages while it runs.

Parameters:
len, 32, width of PC values

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
pc_in  in  len  PC+4 of the instruction in EXE
wb_en_in  in  1  write-back enable from ID/EXE
mem_read_in  in  1  load flag
mem_write_in  in  1  store flag
flush_in  in  1  instruction squashed; treat as bubble
branch_type  in  2  00 none, 01 BEZ, 10 BNE, 11 JMP
exe_cmd  in  4  ALU operation
reg2_in  in  32  store data / BNE compare operand
alu_inp1  in  32  ALU operand A
alu_inp2  in  32  ALU operand B / branch offset in words
dest_in  in  5  destination register
branch_taken  out  1  combinational redirect request to IF, and flush request to ID
branch_addr  out  len  combinational branch target
stall  out  1  combinational; upstream holds PC, IF/ID and ID/EXE while high
pc_out, wb_en_out, mem_read_out, mem_write_out, alu_result_out[32], reg2_out[32], dest_out[5]  out  registered EXE/MEM fields

Behaviour:
- Reset:
  - All registered outputs are 0.
  - FSM goes to IDLE; multiplier counter and accumulator are 0.
- exe_cmd encoding:
  - 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR.
  - 1000 SLL, 1001 SRA, 1010 SRL. Shift amount is alu_inp2[4:0].
  - 1100 MUL: low 32 bits of the unsigned product.
  - Any other code: result = alu_inp1.
  - Arithmetic wraps modulo 2^32.
- valid = ~flush_in.
- A bubble is wb_en, mem_read and mem_write all 0. Data fields are don't-care but driven 0.
- Branch logic:
  - branch_taken = valid & ((type==01 & alu_inp1==0) | (type==10 & alu_inp1!=reg2_in) | type==11).
  - branch_addr = pc_in + (alu_inp2<<2), truncated to len bits.
  - Branch instructions always carry wb_en=0 and are never MUL.
- Single-cycle ops: EXE/MEM registers load the result and passthrough fields at the next edge (latency 1). A flushed instruction loads a bubble.
- FSM states: IDLE, BUSY, DONE.
  - IDLE:
    - If valid & exe_cmd==MUL: stall=1.
    - At the edge: latch both operands, clear the accumulator, count=0, go to BUSY, EXE/MEM loads a bubble.
    - Otherwise normal single-cycle operation, stall=0.
  - BUSY:
    - stall=1.
    - Each edge performs one shift-add step: if multiplier bit0 is set, acc += multiplicand; then multiplicand<<=1 and multiplier>>=1.
    - EXE/MEM loads a bubble.
    - After the step with count==31, go to DONE; otherwise count+1.
  - DONE:
    - stall=0; the held ID/EXE fields are still presented.
    - At the edge: EXE/MEM loads acc plus the passthrough fields, go to IDLE. Upstream advances on the same edge.
- MUL timing:
  - stall is high for exactly 33 consecutive cycles.
  - The result appears at EXE/MEM 34 edges after the MUL is first presented.
- flush_in is sampled only in IDLE and ignored in BUSY/DONE, since upstream is frozen.
- branch_taken is forced 0 in BUSY/DONE.
- Reset asserted in any state takes priority at that edge and aborts the multiply.
- Back-to-back MULs:
  - The second MUL is presented in the cycle after DONE, with state IDLE.
  - It starts a fresh 33-cycle stall; there is no overlap.

Test Plan:
- ADD: alu_inp1=0x7FFFFFFF, alu_inp2=1, wb_en=1, dest=5 -> next edge alu_result_out=0x80000000, dest_out=5, wb_en_out=1.
- SRA: alu_inp1=0xF0000000, alu_inp2=4 -> 0xFF000000. SRL gives 0x0F000000. SLL with alu_inp2=0x21 shifts by 1.
- Branches with pc_in=0x100, alu_inp2=0xFFFFFFFE:
  - BEZ, alu_inp1=0 -> branch_taken=1, branch_addr=0xF8.
  - BNE with equal operands -> branch_taken=0.
  - JMP with flush_in=1 -> branch_taken=0 and bubble out.
- MUL 0x0001_0003 × 0x0000_0005:
  - stall high for 33 cycles; EXE/MEM holds bubbles throughout.
  - Then alu_result_out=0x0005_000F.
  - Also: 0xFFFFFFFF×0xFFFFFFFF -> 0x00000001.
- Reset asserted at BUSY count=10 -> next edge stall=0, FSM IDLE, all outputs 0. A subsequent ADD completes in 1 cycle.
- Two MULs back-to-back, then an ADD:
  - Two separate 33-cycle stalls with correct results in order.
  - The ADD result appears one edge after the second MUL result.
